chad_coproc: RTL and testbench



---
 rtl/chad_coproc.sv | 148 ++++++++++++++
 tb/tb_chad_coproc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/chad_coproc.sv
// rtl/chad_coproc.sv - iterative unsigned multiply/divide coprocessor for the chad core
module chad_coproc #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             go,
  input  logic [10:0]      sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {Y_LO, Y_HI, Y_STAT} ysel_t;

  state_t           state, state_nx;
  ysel_t            ysel;
  logic [WIDTH-1:0] lo, hi, opnd;
  logic             ovf, is_div;
  logic [CW-1:0]    cnt;

  logic [2:0]       op;
  logic             start_mul, start_div, div_ovf;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic             unused_sel;

  assign op         = sel[2:0];
  assign unused_sel = ^sel[10:3];
  assign start_mul  = (state == IDLE) && go && (op == 3'd1);
  assign start_div  = (state == IDLE) && go && (op == 3'd2);
  // The quotient only fits in WIDTH bits when the high dividend word is below the divisor.
  assign div_ovf    = (c >= a);

  // hi carries one extra bit while summing; the shifted-out carry becomes the new hi MSB.
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  // Partial remainder after the left shift can exceed WIDTH bits, so compare at WIDTH+1.
  assign div_sh   = {hi, lo[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, opnd});
  assign div_diff = div_sh[WIDTH-1:0] - opnd;

  // State register.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state and stall decode; busy rises in the go cycle itself so the core holds at once.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        busy = start_mul | start_div;
        if (start_mul || (start_div && !div_ovf)) state_nx = RUN;
        else if (start_div)                       state_nx = DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, one shift-add or restoring-divide step per RUN cycle, and result select.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      lo     <= '0;
      hi     <= '0;
      opnd   <= '0;
      ovf    <= 1'b0;
      is_div <= 1'b0;
      cnt    <= '0;
      ysel   <= Y_LO;
    end else begin
      case (state)
        IDLE: begin
          if (start_mul) begin
            opnd   <= a;
            hi     <= '0;
            lo     <= b;
            ovf    <= 1'b0;
            is_div <= 1'b0;
            cnt    <= CW'(WIDTH);
            ysel   <= Y_LO;
          end else if (start_div) begin
            opnd   <= a;
            is_div <= 1'b1;
            cnt    <= CW'(WIDTH);
            ysel   <= Y_LO;
            if (div_ovf) begin
              lo  <= '1;
              hi  <= '1;
              ovf <= 1'b1;
            end else begin
              hi  <= c;
              lo  <= b;
              ovf <= 1'b0;
            end
          end else if (go) begin
            case (op)
              3'd4:    ysel <= Y_LO;
              3'd5:    ysel <= Y_HI;
              3'd6:    ysel <= Y_STAT;
              default: ysel <= ysel;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            if (div_ge) begin
              hi <= div_diff;
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= div_sh[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Result mux onto the core's cop input.
  always_comb begin
    y = lo;
    case (ysel)
      Y_LO:    y = lo;
      Y_HI:    y = hi;
      Y_STAT:  y = {{(WIDTH-2){1'b0}}, (state == RUN), ovf};
      default: y = lo;
    endcase
  end

endmodule

// File: tb/tb_chad_coproc.sv
// tb/tb_chad_coproc.sv - scoreboard bench for chad_coproc at WIDTH=18
module tb_chad_coproc;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         resetq = 1'b0;
  logic         go = 1'b0;
  logic [10:0]  sel = '0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic [W-1:0] y;
  logic         busy;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  chad_coproc #(.WIDTH(W)) dut (
    .clk(clk), .resetq(resetq), .go(go), .sel(sel),
    .a(a), .b(b), .c(c), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] ia, ib, ic);
    exp_t e;
    logic [2*W-1:0] p, q, r;
    if (op == 3'd1) begin
      p = {{W{1'b0}}, ia} * {{W{1'b0}}, ib};
      e.lo = p[W-1:0]; e.hi = p[2*W-1:W]; e.ovf = 1'b0; e.cyc = W + 1;
    end else if (ic >= ia) begin
      e.lo = '1; e.hi = '1; e.ovf = 1'b1; e.cyc = 1;
    end else begin
      q = {ic, ib} / {{W{1'b0}}, ia};
      r = {ic, ib} % {{W{1'b0}}, ia};
      e.lo = q[W-1:0]; e.hi = r[W-1:0]; e.ovf = 1'b0; e.cyc = W + 1;
    end
    return e;
  endfunction

  // Called just after a falling edge; leaves the bench inside the go cycle.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] ia, ib, ic);
    sb.push_back(model(op, ia, ib, ic));
    go = 1'b1; sel = {8'h00, op}; a = ia; b = ib; c = ic;
    #1;
  endtask

  // Counts stall cycles from the go cycle; returns in the first DONE cycle.
  task automatic wait_done(output exp_t e);
    int n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
    e = sb.pop_front();
    chk("busy_cycles", 32'(n), 32'(e.cyc));
    chk("y_lo_done", 32'(y), 32'(e.lo));
  endtask

  // From DONE: release go, then read HI, STAT and LO through select ops.
  task automatic check_results(input exp_t e);
    go = 1'b0;
    @(negedge clk); #1;
    go = 1'b1; sel = 11'd5; #1;
    chk("sel_busy", 32'(busy), 32'd0);
    @(negedge clk); #1;
    go = 1'b0;
    chk("y_hi", 32'(y), 32'(e.hi));
    go = 1'b1; sel = 11'd6;
    @(negedge clk); #1;
    go = 1'b0;
    chk("y_stat", 32'(y), {31'd0, e.ovf});
    go = 1'b1; sel = 11'd4;
    @(negedge clk); #1;
    go = 1'b0;
    chk("y_lo", 32'(y), 32'(e.lo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb, rc;
    logic [2:0]   rop;

    #1;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); resetq = 1'b1;
    @(negedge clk);

    // Full-scale multiply.
    start_op(3'd1, 18'h3FFFF, 18'h3FFFF, 18'h0);
    chk("go_busy", 32'(busy), 32'd1);
    wait_done(e);
    check_results(e);

    // Non-overflow divide.
    @(negedge clk);
    start_op(3'd2, 18'h00003, 18'h00000, 18'h00001);
    wait_done(e);
    check_results(e);

    // Select-only ops: STAT then LO, each switching one edge later.
    @(negedge clk);
    go = 1'b1; sel = 11'd6; #1;
    chk("sel6_busy", 32'(busy), 32'd0);
    chk("sel6_pre", 32'(y), 32'h15555);
    @(negedge clk); #1;
    chk("sel6_post", 32'(y), 32'd0);
    sel = 11'd4; #1;
    chk("sel4_busy", 32'(busy), 32'd0);
    chk("sel4_pre", 32'(y), 32'd0);
    @(negedge clk); #1;
    go = 1'b0;
    chk("sel4_post", 32'(y), 32'h15555);
    go = 1'b1; sel = 11'd5;
    @(negedge clk); #1;
    go = 1'b0;
    chk("hi_kept", 32'(y), 32'h00001);

    // Divide overflow.
    @(negedge clk);
    start_op(3'd2, 18'h00005, 18'h00000, 18'h00005);
    wait_done(e);
    check_results(e);

    // Valid multiply clears ovf.
    @(negedge clk);
    start_op(3'd1, 18'h00002, 18'h00003, 18'h0);
    wait_done(e);
    check_results(e);

    // Divide by zero counts as overflow.
    @(negedge clk);
    start_op(3'd2, 18'h00000, 18'h12345, 18'h00000);
    wait_done(e);
    check_results(e);

    // go held through DONE and one more cycle starts exactly one new multiply.
    @(negedge clk);
    start_op(3'd1, 18'h12345, 18'h00ABC, 18'h0);
    wait_done(e);
    chk("done_busy", 32'(busy), 32'd0);
    sb.push_back(model(3'd1, 18'h2AAAA, 18'h15555, 18'h0));
    a = 18'h2AAAA; b = 18'h15555;
    @(negedge clk); #1;
    chk("second_start", 32'(busy), 32'd1);
    wait_done(e);
    check_results(e);

    // Asynchronous reset during RUN cycle 7.
    @(negedge clk);
    start_op(3'd1, 18'h3FFFF, 18'h3FFFF, 18'h0);
    repeat (7) @(negedge clk);
    #2;
    chk("run_busy", 32'(busy), 32'd1);
    go = 1'b0; resetq = 1'b0; #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_y", 32'(y), 32'd0);
    e = sb.pop_front();
    @(negedge clk); resetq = 1'b1;
    @(negedge clk);
    go = 1'b1; sel = 11'd6;
    @(negedge clk); #1;
    go = 1'b0;
    chk("arst_stat", 32'(y), 32'd0);
    @(negedge clk);
    start_op(3'd1, 18'h0ABCD, 18'h01234, 18'h0);
    wait_done(e);
    check_results(e);

    // Random mix with junk in the ignored select bits.
    for (int i = 0; i < 6; i++) begin
      rop = (i % 2 == 0) ? 3'd1 : 3'd2;
      ra = 18'($urandom);
      rb = 18'($urandom);
      rc = 18'($urandom_range(0, 32'h3FFFF));
      if (rop == 3'd2 && i != 5) rc = rc % (ra | 18'd1);
      if (rop == 3'd2 && ra == 0) ra = 18'd7;
      @(negedge clk);
      sb.push_back(model(rop, ra, rb, rc));
      go = 1'b1; sel = {8'(($urandom % 256)), rop}; a = ra; b = rb; c = rc;
      #1;
      wait_done(e);
      check_results(e);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
